// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the next-PC sequencer: FSM state encodings,
// next-PC select codes and default reset/step values.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    S_FETCH  = 2'b00,
    S_DECODE = 2'b01,
    S_UPDATE = 2'b10
  } seqState_t;

  localparam logic [1:0] SEL_SEQ = 2'b00;
  localparam logic [1:0] SEL_BR  = 2'b01;
  localparam logic [1:0] SEL_JMP = 2'b10;
  localparam logic [1:0] SEL_JR  = 2'b11;

  localparam logic [15:0] DEF_RESET_PC = 16'h0000;
  localparam logic [15:0] DEF_PC_STEP  = 16'd2;

endpackage

// File: rtl/jump_target_gen.sv
// Jump-target combiner: keeps the 4-bit region of the incremented PC and
// replaces the low 12 bits with the instruction's absolute field.
module jump_target_gen (
  input  logic [15:0] pcPlus,
  input  logic [15:0] ir,
  output logic [15:0] target
);

  // Bits of the operands that never reach the target.
  logic [15:0] unusedBits;

  assign unusedBits = {pcPlus[11:0], ir[15:12]};
  assign target     = {pcPlus[15:12], ir[11:0]};

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC controller for the 16-bit multicycle processor.
// Owns the PC and IR, runs the fetch handshake, and picks the next PC from
// sequential / branch / jump / register-indirect sources.
// Optional feature macro: PC_SEQ_LINK_EN enables the jal/jalr link write;
// without it linkIN is ignored and linkWeOUT/linkOUT stay 0.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC = DEF_RESET_PC,
  parameter logic [15:0] PC_STEP  = DEF_PC_STEP
) (
  input  logic        clkIN,
  input  logic        resetnIN,
  output logic        imemReqOUT,
  output logic [15:0] imemAddrOUT,
  input  logic        imemAckIN,
  input  logic [15:0] imemDataIN,
  output logic [15:0] irOUT,
  output logic        irValidOUT,
  input  logic        ctlValidIN,
  input  logic [1:0]  ctlSelIN,
  input  logic        branchTakenIN,
  input  logic [15:0] regIN,
  input  logic        stallIN,
  input  logic        linkIN,
  output logic        linkWeOUT,
  output logic [15:0] linkOUT,
  output logic [15:0] pcOUT
);

  seqState_t   state, nextState;
  logic        fetchEn;
  logic [15:0] pcReg;
  logic [15:0] irReg;
  logic [1:0]  selReg;
  logic        brTakenReg;
  logic [15:0] regReg;

  logic        irLoad;
  logic        ctlLoad;
  logic        pcLoad;

  logic [15:0] pcPlus;
  logic [15:0] brTarget;
  logic [15:0] jmpTarget;
  logic [15:0] nextPc;

  // PC-relative branch: sign-extended 8-bit word displacement, wraps mod 2^16.
  function automatic logic [15:0] branchTarget(input logic [15:0] base,
                                               input logic [7:0]  disp);
    logic signed [15:0] offset;
    offset = {{7{disp[7]}}, disp, 1'b0};
    return base + $unsigned(offset);
  endfunction

  // State register plus PC/IR/decision capture; reset wins over any ack.
  always_ff @(posedge clkIN) begin
    if (!resetnIN) begin
      state      <= S_FETCH;
      fetchEn    <= 1'b0;
      pcReg      <= RESET_PC;
      irReg      <= '0;
      selReg     <= SEL_SEQ;
      brTakenReg <= 1'b0;
    end else begin
      state   <= nextState;
      fetchEn <= 1'b1;
      if (irLoad) irReg <= imemDataIN;
      if (ctlLoad) begin
        selReg     <= ctlSelIN;
        brTakenReg <= branchTakenIN;
      end
      if (pcLoad) pcReg <= nextPc;
    end
  end

  // Register-indirect target is pure data; it is only read after capture.
  always_ff @(posedge clkIN) begin
    if (ctlLoad) regReg <= regIN;
  end

  // Next-state logic and per-state strobes for the fetch/decode/update loop.
  always_comb begin
    nextState  = state;
    imemReqOUT = 1'b0;
    irValidOUT = 1'b0;
    irLoad     = 1'b0;
    ctlLoad    = 1'b0;
    pcLoad     = 1'b0;
    unique case (state)
      S_FETCH: begin
        imemReqOUT = fetchEn;
        if (fetchEn && imemAckIN) begin
          irLoad    = 1'b1;
          nextState = S_DECODE;
        end
      end
      S_DECODE: begin
        irValidOUT = 1'b1;
        if (ctlValidIN) begin
          ctlLoad   = 1'b1;
          nextState = S_UPDATE;
        end
      end
      S_UPDATE: begin
        if (!stallIN) begin
          pcLoad    = 1'b1;
          nextState = S_FETCH;
        end
      end
      default: nextState = S_FETCH;
    endcase
  end

  assign pcPlus   = pcReg + PC_STEP;
  assign brTarget = branchTarget(pcPlus, irReg[7:0]);

  jump_target_gen uJumpTarget (
    .pcPlus (pcPlus),
    .ir     (irReg),
    .target (jmpTarget)
  );

  // Next-PC mux driven by the decision captured in S_DECODE.
  always_comb begin
    nextPc = pcPlus;
    unique case (selReg)
      SEL_SEQ: nextPc = pcPlus;
      SEL_BR:  nextPc = brTakenReg ? brTarget : pcPlus;
      SEL_JMP: nextPc = jmpTarget;
      SEL_JR:  nextPc = regReg;
      default: nextPc = pcPlus;
    endcase
  end

  assign pcOUT       = pcReg;
  assign imemAddrOUT = pcReg;
  assign irOUT       = irReg;

`ifdef PC_SEQ_LINK_EN
  logic linkReg;

  // Link request travels with the rest of the captured decision.
  always_ff @(posedge clkIN) begin
    if (!resetnIN) begin
      linkReg <= 1'b0;
    end else if (ctlLoad) begin
      linkReg <= linkIN;
    end
  end

  // Strobe only on the cycle the PC actually moves, so stalls delay it.
  assign linkWeOUT = pcLoad && linkReg && selReg[1];
  assign linkOUT   = linkWeOUT ? pcPlus : 16'h0000;
`else
  logic unusedLinkIn;

  assign unusedLinkIn = linkIN;
  assign linkWeOUT    = 1'b0;
  assign linkOUT      = 16'h0000;
`endif

endmodule
